seg7_scan_display: RTL and testbench

//  Downstream consumer of the MD5 search driver's status/target outputs. Time-multiplexes the 32-bit target

---
 rtl/seg7_scan_display.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_display.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: scans a 32-bit value as hex onto an 8-digit common-anode
// 7-segment display. Five status flags drive the decimal points of digits 0..4,
// and the whole display blinks while the found flag is set. The value and the
// flags are copied into shadow registers once per frame, so a digit never shows
// half of an old value and half of a new one.
module seg7_scan_display #(
  parameter int unsigned DIGIT_TICKS   = 100000,
  parameter int unsigned GUARD_TICKS   = 16,
  parameter int unsigned BLINK_FRAMES  = 62,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        CLK,
  input  logic        CPU_RESETN,
  input  logic [31:0] target,
  input  logic        status_done,
  input  logic        status_found,
  input  logic        status_warming,
  input  logic        status_running,
  input  logic        status_paused,
  output logic [7:0]  SEG,
  output logic [7:0]  DIGIT
);

  localparam int unsigned PW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(DIGIT_TICKS - 1);
  localparam logic [FW-1:0] FRAME_LAST  = FW'(BLINK_FRAMES - 1);
  localparam logic [PW:0]   GUARD_LIMIT = (PW + 1)'(GUARD_TICKS);

  // Slot timing, frame/blink bookkeeping and the frame-synchronous shadow copy.
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blinkOn_q, blinkOn_d;
  logic [31:0]   shadowTarget_q, shadowTarget_d;
  logic [4:0]    shadowStatus_q, shadowStatus_d;

  // Registered pins; one cycle behind the slot counters.
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    digit_q, digit_d;

  logic          tick;
  logic          frameWrap;
  logic [3:0]    nibble;
  logic [6:0]    hexCode;
  logic          upperZero;
  logic          blankDigit;
  logic [7:0]    dpMap;
  logic          dpOn;
  logic          guardActive;
  logic          blinkDark;

  assign tick      = (presc_q == PRESC_LAST);
  assign frameWrap = tick && (idx_q == 3'd7);

  // Advance the digit slot, count frames for the blink and latch new shadows only at the frame wrap.
  always_comb begin
    presc_d        = presc_q + 1'b1;
    idx_d          = idx_q;
    frame_d        = frame_q;
    blinkOn_d      = blinkOn_q;
    shadowTarget_d = shadowTarget_q;
    shadowStatus_d = shadowStatus_q;
    if (tick) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end
    if (frameWrap) begin
      shadowTarget_d = target;
      shadowStatus_d = {status_paused, status_running, status_warming, status_found, status_done};
      if (frame_q == FRAME_LAST) begin
        frame_d   = '0;
        blinkOn_d = ~blinkOn_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Pick the shadowed nibble for the current slot and translate it to active-low g..a segments.
  always_comb begin
    nibble = shadowTarget_q[{idx_q, 2'b00} +: 4];
    case (nibble)
      4'h0:    hexCode = 7'h40;
      4'h1:    hexCode = 7'h79;
      4'h2:    hexCode = 7'h24;
      4'h3:    hexCode = 7'h30;
      4'h4:    hexCode = 7'h19;
      4'h5:    hexCode = 7'h12;
      4'h6:    hexCode = 7'h02;
      4'h7:    hexCode = 7'h78;
      4'h8:    hexCode = 7'h00;
      4'h9:    hexCode = 7'h10;
      4'hA:    hexCode = 7'h08;
      4'hB:    hexCode = 7'h03;
      4'hC:    hexCode = 7'h46;
      4'hD:    hexCode = 7'h21;
      4'hE:    hexCode = 7'h06;
      default: hexCode = 7'h0E;
    endcase
  end

  // Build the next pin values: guard gap first, then blink-off, then the normal digit.
  always_comb begin
    upperZero   = ((shadowTarget_q >> {idx_q, 2'b00}) == 32'd0);
    blankDigit  = BLANK_LEADING && (idx_q != 3'd0) && upperZero;
    dpMap       = {3'b000, shadowStatus_q};
    dpOn        = dpMap[idx_q];
    guardActive = ({1'b0, presc_q} < GUARD_LIMIT);
    blinkDark   = shadowStatus_q[1] && !blinkOn_q;
    seg_d       = 8'hFF;
    digit_d     = 8'hFF;
    if (!guardActive && !blinkDark) begin
      seg_d = {~dpOn, (blankDigit ? 7'h7F : hexCode)};
      if (seg_d != 8'hFF) begin
        digit_d = ~(8'b0000_0001 << idx_q);
      end
    end
  end

  // State and pin registers; reset darkens the display immediately and restarts the scan at digit 0.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      presc_q        <= '0;
      idx_q          <= 3'd0;
      frame_q        <= '0;
      blinkOn_q      <= 1'b1;
      shadowTarget_q <= 32'd0;
      shadowStatus_q <= 5'd0;
      seg_q          <= 8'hFF;
      digit_q        <= 8'hFF;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      frame_q        <= frame_d;
      blinkOn_q      <= blinkOn_d;
      shadowTarget_q <= shadowTarget_d;
      shadowStatus_q <= shadowStatus_d;
      seg_q          <= seg_d;
      digit_q        <= digit_d;
    end
  end

  assign SEG   = seg_q;
  assign DIGIT = digit_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Testbench for seg7_scan_display with short slots (8 cycles, 2 guard cycles, 2-frame blink).
// Expected pin values for whole frames are queued when inputs are set up and
// popped one per clock as the display scans.
module tb_seg7_scan_display;

  logic        CLK;
  logic        CPU_RESETN;
  logic [31:0] target;
  logic        status_done, status_found, status_warming, status_running, status_paused;
  logic [7:0]  SEG;
  logic [7:0]  DIGIT;

  int checks = 0;
  int fails  = 0;
  int cyc;
  logic [15:0] sb[$];
  logic [15:0] expv;

  seg7_scan_display #(
    .DIGIT_TICKS(8),
    .GUARD_TICKS(2),
    .BLINK_FRAMES(2),
    .BLANK_LEADING(1'b1)
  ) dut (
    .CLK(CLK),
    .CPU_RESETN(CPU_RESETN),
    .target(target),
    .status_done(status_done),
    .status_found(status_found),
    .status_warming(status_warming),
    .status_running(status_running),
    .status_paused(status_paused),
    .SEG(SEG),
    .DIGIT(DIGIT)
  );

  // Free-running clock, 10 time units per period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bench-side count of rising edges since reset release; output after edge n shows slot n-1.
  always @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) cyc <= 0;
    else             cyc <= cyc + 1;
  end

  // Expected {DIGIT,SEG} for slot s (0..63) of a frame with the given shadow value, flags and blink phase.
  function automatic logic [15:0] exp_pins(input logic [31:0] tgt, input logic [4:0] st,
                                           input bit on, input int s);
    int   pr, ix;
    logic [6:0] code;
    logic [7:0] sg, dg;
    bit   dp, blank;
    pr = s % 8;
    ix = s / 8;
    if (pr < 2) return 16'hFFFF;
    if (st[1] && !on) return 16'hFFFF;
    case ((tgt >> (4 * ix)) & 32'hF)
      0: code = 7'h40;  1: code = 7'h79;  2: code = 7'h24;  3: code = 7'h30;
      4: code = 7'h19;  5: code = 7'h12;  6: code = 7'h02;  7: code = 7'h78;
      8: code = 7'h00;  9: code = 7'h10; 10: code = 7'h08; 11: code = 7'h03;
      12: code = 7'h46; 13: code = 7'h21; 14: code = 7'h06; default: code = 7'h0E;
    endcase
    blank = (ix != 0) && ((tgt >> (4 * ix)) == 32'd0);
    dp    = (ix < 5) && st[ix];
    sg    = {~dp, (blank ? 7'h7F : code)};
    dg    = (sg == 8'hFF) ? 8'hFF : ~(8'd1 << ix);
    return {dg, sg};
  endfunction

  function automatic bit phase_on(input int frame);
    return ((frame / 2) % 2) == 0;
  endfunction

  // Queue the 64 expected pin values of one frame.
  task automatic push_frame(input logic [31:0] tgt, input logic [4:0] st, input bit on);
    for (int s = 0; s < 64; s++) sb.push_back(exp_pins(tgt, st, on, s));
  endtask

  task automatic set_inputs(input logic [31:0] tgt, input logic [4:0] st);
    target         = tgt;
    status_done    = st[0];
    status_found   = st[1];
    status_warming = st[2];
    status_running = st[3];
    status_paused  = st[4];
  endtask

  // Advance to the negedge right after a frame wrap edge, so the next 64 samples form one frame.
  task automatic sync_to_wrap(output int frame);
    int k = 0;
    @(negedge CLK);
    while ((cyc % 64) != 0 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if ((cyc % 64) != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL sync_to_wrap: cyc=%0d never reached a frame boundary", cyc);
    end
    frame = cyc / 64;
  endtask

  task automatic test_reset();
    CPU_RESETN = 1'b0;
    set_inputs(32'd0, 5'd0);
    repeat (20) begin
      @(negedge CLK);
      checks++;
      if ({DIGIT, SEG} !== 16'hFFFF) begin
        fails++;
        $display("[TB] FAIL reset_hold: DIGIT/SEG=%h required=ffff", {DIGIT, SEG});
      end
    end
    CPU_RESETN = 1'b1;
    push_frame(32'd0, 5'd0, 1'b1);
    repeat (64) begin
      @(negedge CLK);
      expv = sb.pop_front();
      checks++;
      if ({DIGIT, SEG} !== expv) begin
        fails++;
        $display("[TB] FAIL reset_first_frame slot=%0d: DIGIT/SEG=%h required=%h", (cyc - 1) % 64, {DIGIT, SEG}, expv);
      end
    end
  endtask

  task automatic test_hex_decode();
    int f;
    set_inputs(32'h1234ABCD, 5'd0);
    sync_to_wrap(f);
    push_frame(32'h1234ABCD, 5'd0, phase_on(f));
    repeat (64) begin
      @(negedge CLK);
      expv = sb.pop_front();
      checks++;
      if ({DIGIT, SEG} !== expv) begin
        fails++;
        $display("[TB] FAIL hex_decode slot=%0d: DIGIT/SEG=%h required=%h", (cyc - 1) % 64, {DIGIT, SEG}, expv);
      end
    end
  endtask

  task automatic test_guard_timing();
    int f;
    set_inputs(32'h89ABCDEF, 5'b11101);
    sync_to_wrap(f);
    push_frame(32'h89ABCDEF, 5'b11101, phase_on(f));
    repeat (64) begin
      @(negedge CLK);
      expv = sb.pop_front();
      checks++;
      if ({DIGIT, SEG} !== expv) begin
        fails++;
        $display("[TB] FAIL guard_timing slot=%0d: DIGIT/SEG=%h required=%h", (cyc - 1) % 64, {DIGIT, SEG}, expv);
      end
    end
  endtask

  task automatic test_tearing();
    int f;
    set_inputs(32'h11111111, 5'd0);
    sync_to_wrap(f);
    push_frame(32'h11111111, 5'd0, 1'b1);
    push_frame(32'h22222222, 5'd0, 1'b1);
    for (int i = 0; i < 128; i++) begin
      @(negedge CLK);
      if (i == 28) target = 32'h22222222;
      expv = sb.pop_front();
      checks++;
      if ({DIGIT, SEG} !== expv) begin
        fails++;
        $display("[TB] FAIL tearing i=%0d: DIGIT/SEG=%h required=%h", i, {DIGIT, SEG}, expv);
      end
    end
  endtask

  task automatic test_leading_blank();
    int f;
    set_inputs(32'h00000100, 5'b10000);
    sync_to_wrap(f);
    push_frame(32'h00000100, 5'b10000, 1'b1);
    repeat (64) begin
      @(negedge CLK);
      expv = sb.pop_front();
      checks++;
      if ({DIGIT, SEG} !== expv) begin
        fails++;
        $display("[TB] FAIL leading_blank slot=%0d: DIGIT/SEG=%h required=%h", (cyc - 1) % 64, {DIGIT, SEG}, expv);
      end
    end
  endtask

  task automatic test_blink();
    int f;
    set_inputs(32'd5, 5'b00010);
    sync_to_wrap(f);
    for (int k = 0; k < 4; k++) push_frame(32'd5, 5'b00010, phase_on(f + k));
    repeat (256) begin
      @(negedge CLK);
      expv = sb.pop_front();
      checks++;
      if ({DIGIT, SEG} !== expv) begin
        fails++;
        $display("[TB] FAIL blink_on slot=%0d: DIGIT/SEG=%h required=%h", (cyc - 1) % 64, {DIGIT, SEG}, expv);
      end
    end
    status_found = 1'b0;
    push_frame(32'd5, 5'b00010, phase_on(f + 4));
    for (int k = 0; k < 4; k++) push_frame(32'd5, 5'd0, 1'b1);
    repeat (320) begin
      @(negedge CLK);
      expv = sb.pop_front();
      checks++;
      if ({DIGIT, SEG} !== expv) begin
        fails++;
        $display("[TB] FAIL blink_stop slot=%0d: DIGIT/SEG=%h required=%h", (cyc - 1) % 64, {DIGIT, SEG}, expv);
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    int f;
    set_inputs(32'h1234ABCD, 5'd0);
    sync_to_wrap(f);
    repeat (21) @(negedge CLK);
    expv = exp_pins(32'h1234ABCD, 5'd0, 1'b1, 20);
    checks++;
    if ({DIGIT, SEG} !== expv) begin
      fails++;
      $display("[TB] FAIL pre_reset_lit: DIGIT/SEG=%h required=%h", {DIGIT, SEG}, expv);
    end
    CPU_RESETN = 1'b0;
    #1;
    checks++;
    if ({DIGIT, SEG} !== 16'hFFFF) begin
      fails++;
      $display("[TB] FAIL reset_immediate: DIGIT/SEG=%h required=ffff", {DIGIT, SEG});
    end
    target = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if ({DIGIT, SEG} !== 16'hFFFF) begin
        fails++;
        $display("[TB] FAIL reset_mid_hold: DIGIT/SEG=%h required=ffff", {DIGIT, SEG});
      end
    end
    CPU_RESETN = 1'b1;
    push_frame(32'd0, 5'd0, 1'b1);
    push_frame(32'hDEADBEEF, 5'd0, 1'b1);
    repeat (128) begin
      @(negedge CLK);
      expv = sb.pop_front();
      checks++;
      if ({DIGIT, SEG} !== expv) begin
        fails++;
        $display("[TB] FAIL reset_restart cyc=%0d: DIGIT/SEG=%h required=%h", cyc, {DIGIT, SEG}, expv);
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_hex_decode();
    test_guard_timing();
    test_tearing();
    test_leading_blank();
    test_blink();
    test_reset_mid_slot();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
